// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, latency constant and cfg clamp for the skewing feeder.
package sa_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} sa_state_e;
  function automatic int sa_latency(input int n);
    return 3 * n - 2;
  endfunction
  function automatic int sa_clamp(input int v, input int n);
    return v > n ? n : v;
  endfunction
endpackage

// File: rtl/sa_skew_lane.sv
// sa_skew_lane: selects element k-(LANE-1) of one captured row/column, zero outside the skew window.
module sa_skew_lane #(
  parameter int N = 4,
  parameter int WDATA = 4,
  parameter int KW = 4,
  parameter int LANE = 1
) (
  input  logic [1:N][WDATA-1:0] vec,
  input  logic [KW-1:0]         k,
  input  logic                  en,
  output logic [WDATA-1:0]      word
);
  always_comb begin
    word = '0;
    for (int m = 1; m <= N; m++) if (en && k == KW'(m + LANE - 2)) word = vec[m];
  end
endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: captures A, B and cfg, pulses the array reset, then feeds a skewed wavefront and drains.
// Optional lane masking by row/col cfg is enabled with SA_FEED_MASK_EN.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int N = 4,
  parameter int WDATA = 4,
  parameter int CFG_WIDTH = $clog2(N) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CFG_WIDTH-1:0]         row_cfg_in,
  input  logic [CFG_WIDTH-1:0]         col_cfg_in,
  input  logic [1:N][1:N][WDATA-1:0]   mat_a,
  input  logic [1:N][1:N][WDATA-1:0]   mat_b,
  output logic                         busy,
  output logic                         done,
  output logic                         sa_rst_n,
  output logic [CFG_WIDTH-1:0]         row_cfg_out,
  output logic [CFG_WIDTH-1:0]         col_cfg_out,
  output logic [1:N][WDATA-1:0]        feed_N,
  output logic [1:N][WDATA-1:0]        feed_W,
  output logic                         feed_valid
);
  localparam int KW = $clog2(3 * N);
  localparam int LAT = sa_latency(N);
  sa_state_e state;
  logic [KW-1:0] k, kn;
  logic [1:N][1:N][WDATA-1:0] a_q, b_q, b_t;
  logic [1:N][WDATA-1:0] w_nx, n_nx;
  logic [1:N] row_en, col_en;
  // Feed outputs are registered, so lanes look one step ahead of the displayed k.
  assign kn = state == CLEAR ? '0 : k + KW'(1);
  for (genvar i = 1; i <= N; i++) begin : g_lane
    for (genvar r = 1; r <= N; r++) begin : g_tr
      assign b_t[i][r] = b_q[r][i];
    end
`ifdef SA_FEED_MASK_EN
    assign row_en[i] = row_cfg_out >= CFG_WIDTH'(i);
    assign col_en[i] = col_cfg_out >= CFG_WIDTH'(i);
`else
    assign row_en[i] = 1'b1;
    assign col_en[i] = 1'b1;
`endif
    sa_skew_lane #(.N(N), .WDATA(WDATA), .KW(KW), .LANE(i)) u_w (
      .vec(a_q[i]), .k(kn), .en(row_en[i]), .word(w_nx[i])
    );
    sa_skew_lane #(.N(N), .WDATA(WDATA), .KW(KW), .LANE(i)) u_n (
      .vec(b_t[i]), .k(kn), .en(col_en[i]), .word(n_nx[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      a_q <= '0;
      b_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sa_rst_n <= 1'b0;
      row_cfg_out <= '0;
      col_cfg_out <= '0;
      feed_N <= '0;
      feed_W <= '0;
      feed_valid <= 1'b0;
    end else begin
      sa_rst_n <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= start ? CLEAR : IDLE;
          if (start) begin
            a_q <= mat_a;
            b_q <= mat_b;
            row_cfg_out <= CFG_WIDTH'(sa_clamp(int'(row_cfg_in), N));
            col_cfg_out <= CFG_WIDTH'(sa_clamp(int'(col_cfg_in), N));
            busy <= 1'b1;
            sa_rst_n <= 1'b0;
            k <= '0;
          end
        end
        CLEAR: begin
          state <= FEED;
          k <= kn;
          feed_W <= w_nx;
          feed_N <= n_nx;
          feed_valid <= 1'b1;
        end
        FEED: begin
          if (k == KW'(2 * N - 2)) begin
            state <= N > 1 ? DRAIN : DONE;
            done <= N == 1;
            busy <= N > 1;
            k <= '0;
            feed_W <= '0;
            feed_N <= '0;
            feed_valid <= 1'b0;
          end else begin
            k <= kn;
            feed_W <= w_nx;
            feed_N <= n_nx;
          end
        end
        DRAIN: begin
          if (k == KW'(LAT - 2 * N)) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            k <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: directed job sequence with random operands, checked per cycle against a skew model.
module tb_sa_feeder;
  localparam int N = 4;
  localparam int WDATA = 4;
  localparam int CW = $clog2(N) + 1;
  typedef logic [1:N][WDATA-1:0] lane_t;

  logic clk, rst_n, start, busy, done, sa_rst_n, feed_valid;
  logic [CW-1:0] row_cfg_in, col_cfg_in, row_cfg_out, col_cfg_out;
  logic [1:N][1:N][WDATA-1:0] mat_a, mat_b;
  lane_t feed_N, feed_W;

  int checks = 0;
  int errors = 0;
  int am [1:N][1:N];
  int bm [1:N][1:N];
  int exp_rc = 0;
  int exp_cc = 0;

  sa_feeder #(.N(N), .WDATA(WDATA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .row_cfg_in(row_cfg_in), .col_cfg_in(col_cfg_in),
    .mat_a(mat_a), .mat_b(mat_b),
    .busy(busy), .done(done), .sa_rst_n(sa_rst_n),
    .row_cfg_out(row_cfg_out), .col_cfg_out(col_cfg_out),
    .feed_N(feed_N), .feed_W(feed_W), .feed_valid(feed_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit lane_on(input int idx, input int cfg);
`ifdef SA_FEED_MASK_EN
    return idx <= cfg;
`else
    return 1'b1;
`endif
  endfunction

  // Step k of the wavefront: lane i shows element (k - (i-1)) of its row/column, 0-based.
  function automatic lane_t exp_w(input int k);
    lane_t v;
    for (int i = 1; i <= N; i++) begin
      int c = k - i + 2;
      v[i] = (c >= 1 && c <= N && lane_on(i, exp_rc)) ? WDATA'(am[i][c]) : '0;
    end
    return v;
  endfunction

  function automatic lane_t exp_n(input int k);
    lane_t v;
    for (int j = 1; j <= N; j++) begin
      int r = k - j + 2;
      v[j] = (r >= 1 && r <= N && lane_on(j, exp_cc)) ? WDATA'(bm[r][j]) : '0;
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        am[i][j] = int'($urandom_range(0, 2 ** WDATA - 1));
        bm[i][j] = int'($urandom_range(0, 2 ** WDATA - 1));
      end
  endtask

  task automatic scramble();
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        mat_a[i][j] = WDATA'($urandom);
        mat_b[i][j] = WDATA'($urandom);
      end
    row_cfg_in = CW'($urandom);
    col_cfg_in = CW'($urandom);
  endtask

  task automatic launch(input int rc, input int cc);
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        mat_a[i][j] = WDATA'(am[i][j]);
        mat_b[i][j] = WDATA'(bm[i][j]);
      end
    row_cfg_in = CW'(rc);
    col_cfg_in = CW'(cc);
    exp_rc = rc > N ? N : rc;
    exp_cc = cc > N ? N : cc;
    start = 1'b1;
    @(negedge clk);
  endtask

  // Entered at a negedge in IDLE or DONE; returns at the negedge of the done cycle.
  task automatic run_job(input int rc, input int cc, input bit poke_feed, input bit hold);
    launch(rc, cc);
    for (int c = 1; c <= 3 * N; c++) begin
      chk("busy", 64'(busy), 64'(c < 3 * N));
      chk("done", 64'(done), 64'(c == 3 * N));
      chk("sa_rst_n", 64'(sa_rst_n), 64'(c != 1));
      chk("feed_valid", 64'(feed_valid), 64'(c >= 2 && c <= 2 * N));
      chk("row_cfg_out", 64'(row_cfg_out), 64'(exp_rc));
      chk("col_cfg_out", 64'(col_cfg_out), 64'(exp_cc));
      chk("feed_W", 64'(feed_W), 64'(exp_w(c - 2)));
      chk("feed_N", 64'(feed_N), 64'(exp_n(c - 2)));
      if (c == 3 * N) begin
        start = hold;
      end else begin
        start = poke_feed && c == 4;
        scramble();
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_valid", 64'(feed_valid), 64'(0));
      chk("idle_sa_rst_n", 64'(sa_rst_n), 64'(1));
      chk("idle_feed", 64'({feed_W, feed_N}), 64'(0));
      chk("idle_cfg", 64'({row_cfg_out, col_cfg_out}), 64'({CW'(exp_rc), CW'(exp_cc)}));
    end
  endtask

  initial begin
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    row_cfg_in = '0;
    col_cfg_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 64'({busy, done, feed_valid, sa_rst_n}), 64'(0));
    chk("rst_feed", 64'({feed_W, feed_N}), 64'(0));
    chk("rst_cfg", 64'({row_cfg_out, col_cfg_out}), 64'(0));
    rst_n = 1'b1;
    #1 chk("rst_release_sa_low", 64'(sa_rst_n), 64'(0));
    idle(2);
    // Ramp pattern A with identity B; cfg 7 clamps to N.
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        am[i][j] = (4 * (i - 1) + j - 1) % 16;
        bm[i][j] = i == j ? 1 : 0;
      end
    run_job(7, 7, 1'b0, 1'b0);
    idle(2);
    // Start during FEED is ignored; start held in DONE launches the next job immediately.
    fill_random();
    run_job(2, 3, 1'b1, 1'b1);
    fill_random();
    run_job(0, 0, 1'b0, 1'b1);
    fill_random();
    run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
    idle(3);
    // Asynchronous reset mid-job.
    fill_random();
    launch(3, 1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_flags", 64'({busy, done, feed_valid, sa_rst_n}), 64'(0));
    chk("abort_feed", 64'({feed_W, feed_N}), 64'(0));
    chk("abort_cfg", 64'({row_cfg_out, col_cfg_out}), 64'(0));
    exp_rc = 0;
    exp_cc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_release_sa_low", 64'(sa_rst_n), 64'(0));
    idle(2);
    fill_random();
    run_job(4, 2, 1'b0, 1'b0);
    idle(1);
    fill_random();
    run_job(1, 4, 1'b1, 1'b0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
